spi_dc_tx_feeder: RTL and testbench
===================================

# spi_dc_tx_feeder

Byte-queueing sequencer that sits directly upstream of the SPI single-bit error-correcting link's transmit side. It accepts bytes from the host into a small FIFO and issues them one at a time to the link's `din`/`start`/`tx_en` inputs. After each `start` it waits for the link's `sed_qvld` completion pulse, then enforces an inter-frame gap before issuing the next byte. It also counts sent frames and flags overflow and completion timeouts.

## Interface
- `DEPTH`, 8: FIFO depth in bytes; power of two, ≥2.
- `GAP`, 4: idle cycles inserted after each frame completes or times out; 0 allowed.
- `TIMEOUT`, 1024: max cycles spent in WAIT for `sed_qvld`; ≥2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  feeder enable; gates popping new bytes.
- `wr_en`  in  1  host write strobe.
- `wr_data`  in  8  host byte.
- `clr_err`  in  1  clears `ovf_err` and `timeout_err`.
- `full`  out  1  FIFO full (count == DEPTH).
- `count`  out  $clog2(DEPTH)+1  bytes queued.
- `tx_en`  out  1  link transmit enable; combinationally equal to `en`.
- `start`  out  1  one-cycle frame request to link.
- `din`  out  8  byte to link; registered.
- `sed_qvld`  in  1  link frame-complete pulse.
- `busy`  out  1  high in any state other than IDLE.
- `sent_cnt`  out  16  frames completed with `sed_qvld`; wraps 0xFFFF→0.
- `ovf_err`  out  1  sticky: write attempted while full.
- `timeout_err`  out  1  sticky: WAIT expired.

## Operation
- FIFO: circular buffer with read/write pointers and a registered `count`.
  - Write accepted when `wr_en && !full`.
  - Write while `full` is dropped and sets `ovf_err`. This holds even if a pop happens in the same cycle, because `full` is judged from the registered count.
  - Simultaneous accepted write and pop: `count` unchanged; both pointers advance.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, WAIT, GAP.
  - IDLE: if `en && count!=0`, pop the head into `din` and go to START. Otherwise stay.
  - START: `start`=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
  - WAIT: if `sed_qvld`, increment `sent_cnt` and go to GAP.
    - Else if the timeout counter reaches TIMEOUT-1, set `timeout_err`, drop the byte (no retry) and go to GAP.
    - Else increment the counter.
    - If `sed_qvld` and expiry coincide, success wins and `timeout_err` is not set.
  - GAP: load a gap counter with GAP on entry, decrement each cycle, and go to IDLE when it reaches 0. If GAP=0, WAIT goes directly to IDLE.
- `din` holds its value from START until the next pop. It is never changed during WAIT.
- `sed_qvld` is ignored outside WAIT.
- Deasserting `en` mid-frame does not abort: the current frame runs through WAIT/GAP, and no further pops occur.
- `clr_err` clears both sticky flags. If a set event occurs in the same cycle as `clr_err`, set wins.

## Timing
- Reset values:
  - State IDLE.
  - `start`=0, `din`=0x00, `busy`=0.
  - `count`=0, `full`=0, pointers 0.
  - `sent_cnt`=0, `ovf_err`=0, `timeout_err`=0.
  - `tx_en` follows `en`.
- Reset asserted mid-frame returns to IDLE immediately. Queued bytes are discarded and `start` drops asynchronously.
- Latency: write accepted on edge T, `count` updates at T. With `en`=1 and state IDLE, the pop occurs at edge T+1, and `start` and the new `din` are high/valid during cycle T+1..T+2.
- `sed_qvld` sampled at edge E: GAP spans E..E+GAP, and the next `start` can assert no earlier than GAP+2 cycles after E.
- Minimum frame period = 2 + (cycles to `sed_qvld`) + GAP.
- `sent_cnt` and `timeout_err` update on the same edge that leaves WAIT.

## Test plan
- Reset, then write 0xA5 with `en`=1. Required: one `start` pulse with `din`=0xA5 two cycles after the write. Return `sed_qvld` 20 cycles later. Required: `sent_cnt`=1, `busy` low after GAP+1 cycles.
- Write 8 bytes 0x01..0x08 with `en`=0. Required: `full`=1, `count`=8. A ninth write sets `ovf_err`=1 and the contents are unchanged. Then set `en`=1 and ack each frame. Required: `din` sequence 0x01..0x08 and `sent_cnt`=8.
- Never return `sed_qvld`. Required: `timeout_err`=1 exactly TIMEOUT cycles after START, the next byte is issued after GAP, and `sent_cnt` is unchanged. `clr_err` then clears the flag.
- With FIFO full and popping, hold `wr_en`. Required: the write in the pop cycle is rejected and `ovf_err` set. When not full, simultaneous write and pop leave `count` constant.
- Drop `en` during WAIT. Required: the frame completes with `sent_cnt`+1 and no further `start` until `en` returns.
- Assert `rst` during WAIT with 3 bytes queued. Required: all outputs at reset values immediately and `count`=0 after release.

Source files
------------

// File: rtl/spi_dc_tx_feeder.sv
// spi_dc_tx_feeder: byte FIFO plus frame sequencer in front of the SPI ECC link transmitter.
// Host bytes are queued, then issued one at a time on din/start. The feeder waits for the
// link's sed_qvld completion pulse (or a timeout) and holds an inter-frame gap before the
// next byte.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   en                feeder enable; gates popping of new bytes (tx_en mirrors it)
//   wr_en, wr_data    host write strobe and byte
//   clr_err           clears the sticky ovf_err / timeout_err flags
//   full, count       FIFO full flag and number of queued bytes
//   tx_en, start, din link transmit enable, one-cycle frame request, registered byte
//   sed_qvld          link frame-complete pulse (only looked at while waiting)
//   busy              sequencer not idle
//   sent_cnt          frames acknowledged by sed_qvld (wraps)
//   ovf_err           sticky: write attempted while full
//   timeout_err       sticky: completion wait expired
module spi_dc_tx_feeder #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned GAP     = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   clr_err,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   tx_en,
  output logic                   start,
  output logic [7:0]             din,
  input  logic                   sed_qvld,
  output logic                   busy,
  output logic [15:0]            sent_cnt,
  output logic                   ovf_err,
  output logic                   timeout_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StGap} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      din_q;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [15:0]     sent_q, sent_d;
  logic            ovf_q, ovf_d;
  logic            tmo_err_q, tmo_err_d;
  logic            wr_ok, pop, tmo_evt;

  // full is judged from the registered count, so a write in a pop cycle while full is dropped.
  assign full  = (count_q == CW'(DEPTH));
  assign wr_ok = wr_en && !full;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    sent_d  = sent_q;
    pop     = 1'b0;
    tmo_evt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en && (count_q != '0)) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        tmo_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // Completion beats an expiry landing on the same cycle.
        if (sed_qvld || (tmo_q == TW'(TIMEOUT - 1))) begin
          if (sed_qvld) begin
            sent_d = sent_q + 16'd1;
          end else begin
            tmo_evt = 1'b1;
          end
          if (GAP == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StGap;
            gap_d   = GW'(GAP);
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d   = count_q + CW'(wr_ok) - CW'(pop);
    ovf_d     = (ovf_q && !clr_err) || (wr_en && full);
    tmo_err_d = (tmo_err_q && !clr_err) || tmo_evt;
  end

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      din_q     <= 8'h00;
      tmo_q     <= '0;
      gap_q     <= '0;
      sent_q    <= '0;
      ovf_q     <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
      sent_q    <= sent_d;
      ovf_q     <= ovf_d;
      tmo_err_q <= tmo_err_d;
      // Pointers wrap naturally since DEPTH is a power of two.
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        din_q    <= mem_q[rd_ptr_q];
      end
    end
  end

  assign count       = count_q;
  assign tx_en       = en;
  assign start       = (state_q == StStart);
  assign din         = din_q;
  assign busy        = (state_q != StIdle);
  assign sent_cnt    = sent_q;
  assign ovf_err     = ovf_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_spi_dc_tx_feeder.sv
// Bench for spi_dc_tx_feeder. Bytes are pushed onto a scoreboard queue when a write is
// expected to be accepted; a monitor pops and compares din on every start pulse.
// Outputs are sampled on the falling edge; inputs are driven right after sampling.
module tb_spi_dc_tx_feeder;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned GAP     = 4;
  localparam int unsigned TIMEOUT = 32;

  logic        clk, rst, en, wr_en, clr_err, sed_qvld;
  logic [7:0]  wr_data;
  logic        full, tx_en, start, busy, ovf_err, timeout_err;
  logic [3:0]  count;
  logic [7:0]  din;
  logic [15:0] sent_cnt;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_start = 0;
  int          exp_sent = 0;
  logic [7:0]  exp_q[$];

  spi_dc_tx_feeder #(
    .DEPTH  (DEPTH),
    .GAP    (GAP),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .clr_err    (clr_err),
    .full       (full),
    .count      (count),
    .tx_en      (tx_en),
    .start      (start),
    .din        (din),
    .sed_qvld   (sed_qvld),
    .busy       (busy),
    .sent_cnt   (sent_cnt),
    .ovf_err    (ovf_err),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every start must present the oldest accepted, not-yet-issued byte.
  always @(negedge clk) begin
    if (rst && start) begin
      logic [7:0] e;
      n_start++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL din_seq: unexpected start with din=%02h, queue empty", din);
      end else begin
        e = exp_q.pop_front();
        if (din !== e) begin
          n_err++;
          $display("FAIL din_seq: din=%02h expected %02h", din, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_start();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!start && k < 300);
    n_cmp++;
    if (!start) begin
      n_err++;
      $display("FAIL wait_start: no start within %0d cycles", k);
    end
  endtask

  // Raise sed_qvld d cycles after the current sample, for one cycle.
  task automatic pulse_ack(input int d);
    repeat (d) @(negedge clk);
    sed_qvld = 1'b1;
    @(negedge clk);
    sed_qvld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_err = 1'b0; sed_qvld = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({start, din, busy, count, full, sent_cnt, ovf_err, timeout_err} !== 33'h0) begin
      n_err++;
      $display("FAIL reset_vals: start=%b din=%02h busy=%b count=%0d full=%b sent=%0d ovf=%b to=%b",
               start, din, busy, count, full, sent_cnt, ovf_err, timeout_err);
    end
    rst = 1'b1;
    en  = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (tx_en !== 1'b1) begin
      n_err++;
      $display("FAIL tx_en: got %b expected 1", tx_en);
    end
  endtask

  task automatic test_single();
    wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
    @(negedge clk);
    wr_en = 1'b0;
    n_cmp++;
    if (count !== 4'd1 || start !== 1'b0) begin
      n_err++;
      $display("FAIL single_wr: count=%0d start=%b expected 1,0", count, start);
    end
    @(negedge clk);
    n_cmp++;
    if (start !== 1'b1 || din !== 8'hA5 || count !== 4'd0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_start: start=%b din=%02h count=%0d busy=%b expected 1,a5,0,1",
               start, din, count, busy);
    end
    pulse_ack(20);
    exp_sent++;
    n_cmp++;
    if (sent_cnt !== 16'(exp_sent) || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_done: sent=%0d busy=%b expected %0d,1", sent_cnt, busy, exp_sent);
    end
    repeat (GAP) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL gap_len: busy=%b expected 1 at end of gap", busy);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL gap_end: busy=%b expected 0 after gap", busy);
    end
  endtask

  task automatic test_fill_ovf();
    en = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = 8'(i); exp_q.push_back(8'(i));
    end
    @(negedge clk);
    wr_en = 1'b0;
    n_cmp++;
    if (full !== 1'b1 || count !== 4'd8 || ovf_err !== 1'b0) begin
      n_err++;
      $display("FAIL fill: full=%b count=%0d ovf=%b expected 1,8,0", full, count, ovf_err);
    end
    wr_en = 1'b1; wr_data = 8'h99;
    @(negedge clk);
    wr_en = 1'b0;
    n_cmp++;
    if (ovf_err !== 1'b1 || count !== 4'd8) begin
      n_err++;
      $display("FAIL ovf_set: ovf=%b count=%0d expected 1,8", ovf_err, count);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_cmp++;
    if (ovf_err !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clr: ovf=%b expected 0", ovf_err);
    end
    clr_err = 1'b1; wr_en = 1'b1; wr_data = 8'h98;
    @(negedge clk);
    clr_err = 1'b0; wr_en = 1'b0;
    n_cmp++;
    if (ovf_err !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set_wins: ovf=%b expected 1", ovf_err);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_start();
      pulse_ack(3);
      exp_sent++;
    end
    repeat (GAP + 2) @(negedge clk);
    n_cmp++;
    if (sent_cnt !== 16'(exp_sent) || count !== 4'd0 || busy !== 1'b0 || ovf_err !== 1'b0) begin
      n_err++;
      $display("FAIL fill_drain: sent=%0d count=%0d busy=%b ovf=%b expected %0d,0,0,0",
               sent_cnt, count, busy, ovf_err, exp_sent);
    end
  endtask

  task automatic test_timeout();
    wr_en = 1'b1; wr_data = 8'h31; exp_q.push_back(8'h31);
    @(negedge clk);
    wr_data = 8'h32; exp_q.push_back(8'h32);
    @(negedge clk);
    wr_en = 1'b0;
    n_cmp++;
    if (start !== 1'b1) begin
      n_err++;
      $display("FAIL to_start: start=%b expected 1", start);
    end
    // WAIT lasts TIMEOUT cycles after the start cycle; the flag rises on the edge leaving it.
    for (int j = 1; j <= TIMEOUT + 1; j++) begin
      @(negedge clk);
      if (j == TIMEOUT) begin
        n_cmp++;
        if (timeout_err !== 1'b0) begin
          n_err++;
          $display("FAIL to_early: timeout_err=%b expected 0 at cycle %0d", timeout_err, j);
        end
      end
    end
    n_cmp++;
    if (timeout_err !== 1'b1 || sent_cnt !== 16'(exp_sent)) begin
      n_err++;
      $display("FAIL to_set: timeout_err=%b sent=%0d expected 1,%0d",
               timeout_err, sent_cnt, exp_sent);
    end
    repeat (GAP + 1) @(negedge clk);
    n_cmp++;
    if (start !== 1'b0) begin
      n_err++;
      $display("FAIL to_gap: start=%b expected 0 before gap ends", start);
    end
    @(negedge clk);
    n_cmp++;
    if (start !== 1'b1) begin
      n_err++;
      $display("FAIL to_next: start=%b expected 1 at GAP+2 after timeout", start);
    end
    pulse_ack(2);
    exp_sent++;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_cmp++;
    if (timeout_err !== 1'b0 || sent_cnt !== 16'(exp_sent)) begin
      n_err++;
      $display("FAIL to_clr: timeout_err=%b sent=%0d expected 0,%0d",
               timeout_err, sent_cnt, exp_sent);
    end
    repeat (GAP + 2) @(negedge clk);
  endtask

  task automatic test_full_pop();
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = 8'h41 + 8'(i); exp_q.push_back(8'h41 + 8'(i));
    end
    @(negedge clk);
    // Pop and write in the same cycle while full: the write is dropped.
    en = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    @(negedge clk);
    wr_en = 1'b0;
    n_cmp++;
    if (count !== 4'd7 || ovf_err !== 1'b1 || start !== 1'b1) begin
      n_err++;
      $display("FAIL full_pop: count=%0d ovf=%b start=%b expected 7,1,1", count, ovf_err, start);
    end
    pulse_ack(2);
    exp_sent++;
    repeat (GAP + 1) @(negedge clk);
    // This cycle is IDLE with bytes queued: the pop lands on the coming edge.
    wr_en = 1'b1; wr_data = 8'hEF; exp_q.push_back(8'hEF);
    @(negedge clk);
    wr_en = 1'b0;
    n_cmp++;
    if (count !== 4'd7 || start !== 1'b1) begin
      n_err++;
      $display("FAIL wr_pop_same: count=%0d start=%b expected 7,1", count, start);
    end
    pulse_ack(2);
    exp_sent++;
    for (int i = 0; i < 7; i++) begin
      wait_start();
      pulse_ack(2);
      exp_sent++;
    end
    clr_err = 1'b1;
    repeat (GAP + 2) @(negedge clk);
    clr_err = 1'b0;
    n_cmp++;
    if (sent_cnt !== 16'(exp_sent) || count !== 4'd0 || ovf_err !== 1'b0) begin
      n_err++;
      $display("FAIL full_pop_drain: sent=%0d count=%0d ovf=%b expected %0d,0,0",
               sent_cnt, count, ovf_err, exp_sent);
    end
  endtask

  task automatic test_en_drop();
    int snap;
    wr_en = 1'b1; wr_data = 8'h51; exp_q.push_back(8'h51);
    @(negedge clk);
    wr_data = 8'h52; exp_q.push_back(8'h52);
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    en = 1'b0;
    pulse_ack(3);
    exp_sent++;
    n_cmp++;
    if (sent_cnt !== 16'(exp_sent) || tx_en !== 1'b0) begin
      n_err++;
      $display("FAIL en_drop_done: sent=%0d tx_en=%b expected %0d,0", sent_cnt, tx_en, exp_sent);
    end
    snap = n_start;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (n_start != snap || count !== 4'd1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL en_drop_hold: starts=%0d count=%0d busy=%b expected %0d,1,0",
               n_start, count, busy, snap);
    end
    en = 1'b1;
    wait_start();
    pulse_ack(2);
    exp_sent++;
    repeat (GAP + 2) @(negedge clk);
    n_cmp++;
    if (sent_cnt !== 16'(exp_sent)) begin
      n_err++;
      $display("FAIL en_resume: sent=%0d expected %0d", sent_cnt, exp_sent);
    end
  endtask

  task automatic test_reset_mid();
    int snap;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'h61 + 8'(i); exp_q.push_back(8'h61 + 8'(i));
      @(negedge clk);
    end
    wr_en = 1'b0;
    n_cmp++;
    if (count !== 4'd3 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre: count=%0d busy=%b expected 3,1", count, busy);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({start, din, busy, count, full, sent_cnt, ovf_err, timeout_err} !== 33'h0) begin
      n_err++;
      $display("FAIL rst_mid: start=%b din=%02h busy=%b count=%0d full=%b sent=%0d ovf=%b to=%b",
               start, din, busy, count, full, sent_cnt, ovf_err, timeout_err);
    end
    exp_q.delete();
    exp_sent = 0;
    @(negedge clk);
    rst = 1'b1;
    snap = n_start;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (count !== 4'd0 || busy !== 1'b0 || n_start != snap) begin
      n_err++;
      $display("FAIL rst_release: count=%0d busy=%b starts=%0d expected 0,0,%0d",
               count, busy, n_start, snap);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_ovf();
    test_timeout();
    test_full_pop();
    test_en_drop();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_empty: %0d bytes never issued, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
